pc_update_ctrl: RTL and testbench
=================================

Name: pc_update_ctrl

Overview:
- Sequencer that drives the PC source select and PC write enable of the multicycle CPU's PC-source multiplexer.
- Accepts one-cycle request pulses from the main control unit: sequential fetch, branch, jump, jump-register, return-from-exception and three exception causes.
- Simple requests produce a registered one-cycle PC update.
- Exceptions run a multi-cycle sequence: save EPC, read the handler byte from the vector address, then load PC from the memory-byte path.

Parameters:
- MEM_LAT, 2, memory read latency in cycles between mem_read and valid load-byte data (legal 1..7).
- VEC_OPCODE, 32'd255, vector address for the invalid-opcode exception.
- VEC_OVF, 32'd254, vector address for the arithmetic-overflow exception.
- VEC_DIV0, 32'd253, vector address for the divide-by-zero exception.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_seq  in  1  PC <= PC+4 (ALU result path).
- req_branch  in  1  conditional branch; target already in ALUOut.
- br_type  in  2  00 beq, 01 bne, 10 ble, 11 bgt.
- alu_zero  in  1  ALU zero flag.
- alu_gt  in  1  ALU greater-than flag.
- req_jump  in  1  j/jal; target on shift-left-2 path.
- req_jr  in  1  jr; target passed through the ALU result path.
- req_rte  in  1  return from exception (EPC path).
- exc_opcode  in  1  invalid-opcode exception.
- exc_ovf  in  1  overflow exception.
- exc_div0  in  1  divide-by-zero exception.
- PC_Src  out  3  source select: 000 ALUOut, 001 ALU result, 010 shift-left-2, 011 EPC, 100 load-byte.
- pc_write  out  1  PC write enable.
- epc_write  out  1  EPC write enable.
- mem_read  out  1  memory read strobe for the vector fetch.
- vec_addr  out  32  memory address during the vector fetch.
- exc_cause  out  2  latched cause: 00 none, 01 opcode, 10 ovf, 11 div0.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse on the cycle the PC update is performed.

Behaviour:
- Reset (asynchronous, any state, including mid-exception) forces:
  - state IDLE; PC_Src=001.
  - pc_write, epc_write, mem_read, busy, done = 0.
  - vec_addr=0, exc_cause=00, wait counter=0.
- All outputs are registered.
- States: IDLE, UPD, EXC_SAVE, EXC_WAIT, EXC_LOAD.
- Requests are sampled only in IDLE. Requests arriving while busy=1 are ignored (not queued).
- Priority, highest first: exc_opcode > exc_ovf > exc_div0 > req_rte > req_jump > req_jr > req_branch > req_seq.
- IDLE, with a simple request at edge T (non-exception):
  - Next state is UPD.
  - Registered PC_Src: jump 010, jr 001, rte 011, seq 001, branch 000.
  - Branch taken condition by br_type:
    - beq: alu_zero.
    - bne: !alu_zero.
    - ble: alu_zero | !alu_gt.
    - bgt: alu_gt.
  - pc_write = 1 only if the request is not a branch, or the branch is taken.
  - Not-taken branch: pc_write=0, but UPD is still entered and done still pulses.
- UPD (cycle T+1):
  - Outputs are valid.
  - done=1, busy=1.
  - Next state is IDLE; pc_write and done drop at T+2.
- IDLE, with any exception at edge T:
  - Latch exc_cause.
  - vec_addr = the matching VEC_* value.
  - Next state is EXC_SAVE.
- EXC_SAVE (T+1):
  - epc_write=1, mem_read=1, busy=1.
  - Load counter with MEM_LAT-1.
  - Next state is EXC_WAIT.
- EXC_WAIT:
  - mem_read=0; vec_addr held.
  - Decrement the counter each cycle; leave for EXC_LOAD when it reaches 0.
  - Exactly MEM_LAT cycles are spent here.
- EXC_LOAD (T+2+MEM_LAT):
  - PC_Src=100, pc_write=1, done=1.
  - Next state is IDLE.
  - exc_cause holds its value until the next exception. vec_addr returns to 0.
- epc_write is never asserted outside EXC_SAVE.
- pc_write is never asserted together with epc_write.
- Simultaneous exception and simple request: the exception wins and the simple request is dropped.
- Multiple exceptions in the same cycle: the highest-priority cause only.
- Counter width is 3 bits and never wraps: it stops at 0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - PC_Src encodings (PCSRC_ALUOUT, PCSRC_ALU, PCSRC_SHL2, PCSRC_EPC, PCSRC_LS).
  - br_type encodings.
  - exc_cause encodings.
  - FSM state typedef.
- One natural sub-module: branch_cond_eval, a combinational evaluation of br_type/alu_zero/alu_gt to a taken bit.
- Everything else stays in the top FSM.

Test Plan:
- Reset mid-exception: assert reset low while in EXC_WAIT -> same cycle, all outputs 0, PC_Src=001; after release, a req_seq yields PC_Src=001, pc_write=1 one cycle later.
- Branch matrix: br_type=00 with alu_zero=1 -> PC_Src=000, pc_write=1, done=1 at T+1. br_type=01 with alu_zero=1 -> pc_write=0, done=1. Cover all four types with both flag values.
- Jump and rte: req_jump -> PC_Src=010, pc_write=1 for exactly one cycle. req_rte -> PC_Src=011, epc_write stays 0.
- Overflow exception with MEM_LAT=2:
  - T+1: epc_write=1, mem_read=1, vec_addr=254, exc_cause=10.
  - T+2, T+3: waiting, vec_addr=254 held.
  - T+4: PC_Src=100, pc_write=1, done=1.
  - busy is high T+1..T+4.
- Priority: exc_opcode, exc_div0 and req_jump in the same cycle -> vec_addr=255, exc_cause=01, no jump update.
- Busy drop: req_seq pulsed during EXC_WAIT -> ignored; no extra pc_write after EXC_LOAD, and the state returns to IDLE.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path: PC source select,
// branch types, exception causes and the PC-update sequencer states.
package cpu_ctrl_pkg;

   localparam int unsigned PCSRC_W = 3;
   localparam int unsigned BRT_W   = 2;
   localparam int unsigned CAUSE_W = 2;
   localparam int unsigned STATE_W = 3;
   localparam int unsigned CNT_W   = 3;
   localparam int unsigned ADDR_W  = 32;

   localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 3'b000;
   localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 3'b001;
   localparam logic [PCSRC_W-1:0] PCSRC_SHL2   = 3'b010;
   localparam logic [PCSRC_W-1:0] PCSRC_EPC    = 3'b011;
   localparam logic [PCSRC_W-1:0] PCSRC_LS     = 3'b100;

   localparam logic [BRT_W-1:0] BR_BEQ = 2'b00;
   localparam logic [BRT_W-1:0] BR_BNE = 2'b01;
   localparam logic [BRT_W-1:0] BR_BLE = 2'b10;
   localparam logic [BRT_W-1:0] BR_BGT = 2'b11;

   localparam logic [CAUSE_W-1:0] CAUSE_NONE   = 2'b00;
   localparam logic [CAUSE_W-1:0] CAUSE_OPCODE = 2'b01;
   localparam logic [CAUSE_W-1:0] CAUSE_OVF    = 2'b10;
   localparam logic [CAUSE_W-1:0] CAUSE_DIV0   = 2'b11;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_UPD      = 3'd1;
   localparam state_t ST_EXC_SAVE = 3'd2;
   localparam state_t ST_EXC_WAIT = 3'd3;
   localparam state_t ST_EXC_LOAD = 3'd4;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-taken evaluation from branch type and ALU flags.
module branch_cond_eval
   import cpu_ctrl_pkg::*;
(
   input  logic [BRT_W-1:0] br_type,
   input  logic             alu_zero,
   input  logic             alu_gt,
   output logic             taken_c
);

   always_comb begin
      taken_c = 1'b0;
      case (br_type)
         BR_BEQ:  taken_c = alu_zero;
         BR_BNE:  taken_c = !alu_zero;
         BR_BLE:  taken_c = alu_zero | !alu_gt;
         BR_BGT:  taken_c = alu_gt;
         default: taken_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/pc_update_ctrl.sv
// PC update sequencer: one-cycle updates for simple requests, and a
// save-EPC / vector-fetch / load-PC sequence for exceptions.
module pc_update_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_LAT    = 2,
   parameter logic [31:0] VEC_OPCODE = 32'd255,
   parameter logic [31:0] VEC_OVF    = 32'd254,
   parameter logic [31:0] VEC_DIV0   = 32'd253
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_seq,
   input  logic                req_branch,
   input  logic [BRT_W-1:0]    br_type,
   input  logic                alu_zero,
   input  logic                alu_gt,
   input  logic                req_jump,
   input  logic                req_jr,
   input  logic                req_rte,
   input  logic                exc_opcode,
   input  logic                exc_ovf,
   input  logic                exc_div0,
   output logic [PCSRC_W-1:0]  PC_Src,
   output logic                pc_write,
   output logic                epc_write,
   output logic                mem_read,
   output logic [ADDR_W-1:0]   vec_addr,
   output logic [CAUSE_W-1:0]  exc_cause,
   output logic                busy,
   output logic                done
);

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PCSRC_W-1:0]   pc_src_d;
   logic                 pc_write_d, epc_write_d, mem_read_d, busy_d, done_d;
   logic [ADDR_W-1:0]    vec_addr_d;
   logic [CAUSE_W-1:0]   exc_cause_d;
   logic                 br_taken_c;
   logic                 any_exc_c, any_req_c;

   branch_cond_eval u_branch_cond_eval (
      .br_type  (br_type),
      .alu_zero (alu_zero),
      .alu_gt   (alu_gt),
      .taken_c  (br_taken_c)
   );

   assign any_exc_c = exc_opcode | exc_ovf | exc_div0;
   assign any_req_c = req_rte | req_jump | req_jr | req_branch | req_seq;

   // Next state and next registered output values.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_src_d    = PC_Src;
      pc_write_d  = 1'b0;
      epc_write_d = 1'b0;
      mem_read_d  = 1'b0;
      done_d      = 1'b0;
      vec_addr_d  = vec_addr;
      exc_cause_d = exc_cause;

      case (state_q)
         ST_IDLE: begin
            if (any_exc_c) begin
               state_d     = ST_EXC_SAVE;
               epc_write_d = 1'b1;
               mem_read_d  = 1'b1;
               if (exc_opcode) begin
                  exc_cause_d = CAUSE_OPCODE;
                  vec_addr_d  = VEC_OPCODE;
               end else if (exc_ovf) begin
                  exc_cause_d = CAUSE_OVF;
                  vec_addr_d  = VEC_OVF;
               end else begin
                  exc_cause_d = CAUSE_DIV0;
                  vec_addr_d  = VEC_DIV0;
               end
            end else if (any_req_c) begin
               state_d    = ST_UPD;
               done_d     = 1'b1;
               pc_write_d = 1'b1;
               if (req_rte) begin
                  pc_src_d = PCSRC_EPC;
               end else if (req_jump) begin
                  pc_src_d = PCSRC_SHL2;
               end else if (req_jr) begin
                  pc_src_d = PCSRC_ALU;
               end else if (req_branch) begin
                  pc_src_d   = PCSRC_ALUOUT;
                  pc_write_d = br_taken_c;
               end else begin
                  pc_src_d = PCSRC_ALU;
               end
            end
         end
         ST_UPD: state_d = ST_IDLE;
         ST_EXC_SAVE: begin
            state_d = ST_EXC_WAIT;
            cnt_d   = LAT_LOAD;
         end
         ST_EXC_WAIT: begin
            // Counter saturates at zero; zero means the vector byte is valid.
            if (cnt_q == '0) begin
               state_d    = ST_EXC_LOAD;
               pc_src_d   = PCSRC_LS;
               pc_write_d = 1'b1;
               done_d     = 1'b1;
               vec_addr_d = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_EXC_LOAD: state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         PC_Src    <= PCSRC_ALU;
         pc_write  <= 1'b0;
         epc_write <= 1'b0;
         mem_read  <= 1'b0;
         vec_addr  <= '0;
         exc_cause <= CAUSE_NONE;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         PC_Src    <= pc_src_d;
         pc_write  <= pc_write_d;
         epc_write <= epc_write_d;
         mem_read  <= mem_read_d;
         vec_addr  <= vec_addr_d;
         exc_cause <= exc_cause_d;
         busy      <= busy_d;
         done      <= done_d;
      end
   end

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Self-checking bench for pc_update_ctrl: vector table for simple requests,
// hand-written sequences for exceptions, priority, busy and reset.
module tb_pc_update_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_seq, req_branch, alu_zero, alu_gt;
   logic [1:0]  br_type;
   logic        req_jump, req_jr, req_rte;
   logic        exc_opcode, exc_ovf, exc_div0;
   logic [2:0]  PC_Src;
   logic        pc_write, epc_write, mem_read, busy, done;
   logic [31:0] vec_addr;
   logic [1:0]  exc_cause;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic       seq;
      logic       br;
      logic [1:0] bt;
      logic       z;
      logic       gt;
      logic       j;
      logic       jr;
      logic       rte;
      logic [2:0] exp_src;
      logic       exp_w;
   } vec_t;

   typedef struct packed {
      logic [2:0] pc_src;
      logic       pc_write;
   } upd_t;

   upd_t sb[$];
   vec_t vecs[16];

   pc_update_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .req_seq    (req_seq),
      .req_branch (req_branch),
      .br_type    (br_type),
      .alu_zero   (alu_zero),
      .alu_gt     (alu_gt),
      .req_jump   (req_jump),
      .req_jr     (req_jr),
      .req_rte    (req_rte),
      .exc_opcode (exc_opcode),
      .exc_ovf    (exc_ovf),
      .exc_div0   (exc_div0),
      .PC_Src     (PC_Src),
      .pc_write   (pc_write),
      .epc_write  (epc_write),
      .mem_read   (mem_read),
      .vec_addr   (vec_addr),
      .exc_cause  (exc_cause),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic seq, input logic br, input logic [1:0] bt,
                               input logic z, input logic gt, input logic j,
                               input logic jr, input logic rte,
                               input logic [2:0] src, input logic w);
      vec_t v;
      v.seq = seq; v.br = br; v.bt = bt; v.z = z; v.gt = gt;
      v.j = j; v.jr = jr; v.rte = rte; v.exp_src = src; v.exp_w = w;
      return v;
   endfunction

   task automatic clear_in();
      req_seq = 0; req_branch = 0; br_type = 2'b00; alu_zero = 0; alu_gt = 0;
      req_jump = 0; req_jr = 0; req_rte = 0;
      exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
   endtask

   // Waits (bounded) for done, then pops and compares the expected update.
   task automatic wait_done(input string name, input int budget);
      int   i;
      upd_t e;
      i = 0;
      while (done !== 1'b1 && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (done !== 1'b1) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: done not seen within %0d cycles", name, budget);
         if (sb.size() != 0) void'(sb.pop_front());
      end else if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: unexpected done with empty scoreboard", name);
      end else begin
         e = sb.pop_front();
         chk({name, ".PC_Src"}, 32'(PC_Src), 32'(e.pc_src));
         chk({name, ".pc_write"}, 32'(pc_write), 32'(e.pc_write));
      end
   endtask

   initial begin
      int pw_cnt;
      clear_in();
      reset = 1'b0;

      // beq/bne/ble/bgt with both flag values, then the simple requests and priorities
      vecs[0]  = mk(0,1,2'b00,1,0,0,0,0, 3'b000,1);
      vecs[1]  = mk(0,1,2'b00,0,1,0,0,0, 3'b000,0);
      vecs[2]  = mk(0,1,2'b01,1,0,0,0,0, 3'b000,0);
      vecs[3]  = mk(0,1,2'b01,0,0,0,0,0, 3'b000,1);
      vecs[4]  = mk(0,1,2'b10,0,1,0,0,0, 3'b000,0);
      vecs[5]  = mk(0,1,2'b10,0,0,0,0,0, 3'b000,1);
      vecs[6]  = mk(0,1,2'b11,0,1,0,0,0, 3'b000,1);
      vecs[7]  = mk(0,1,2'b11,1,0,0,0,0, 3'b000,0);
      vecs[8]  = mk(1,0,2'b00,0,0,0,0,0, 3'b001,1);
      vecs[9]  = mk(0,0,2'b00,0,0,1,0,0, 3'b010,1);
      vecs[10] = mk(0,0,2'b00,0,0,0,1,0, 3'b001,1);
      vecs[11] = mk(0,0,2'b00,0,0,0,0,1, 3'b011,1);
      vecs[12] = mk(0,0,2'b00,0,0,1,0,1, 3'b011,1);
      vecs[13] = mk(0,0,2'b00,0,0,1,1,0, 3'b010,1);
      vecs[14] = mk(0,1,2'b00,0,0,0,1,0, 3'b001,1);
      vecs[15] = mk(1,1,2'b00,0,0,0,0,0, 3'b000,0);

      repeat (2) @(negedge clk);
      chk("rst.PC_Src", 32'(PC_Src), 32'd1);
      chk("rst.pc_write", 32'(pc_write), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.vec_addr", vec_addr, 32'd0);
      chk("rst.exc_cause", 32'(exc_cause), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         req_seq = vecs[k].seq; req_branch = vecs[k].br; br_type = vecs[k].bt;
         alu_zero = vecs[k].z; alu_gt = vecs[k].gt; req_jump = vecs[k].j;
         req_jr = vecs[k].jr; req_rte = vecs[k].rte;
         sb.push_back({vecs[k].exp_src, vecs[k].exp_w});
         @(negedge clk);
         clear_in();
         chk($sformatf("v%0d.done_t1", k), 32'(done), 32'd1);
         chk($sformatf("v%0d.busy_t1", k), 32'(busy), 32'd1);
         chk($sformatf("v%0d.epc_write", k), 32'(epc_write), 32'd0);
         wait_done($sformatf("v%0d", k), 0);
         @(negedge clk);
         chk($sformatf("v%0d.done_t2", k), 32'(done), 32'd0);
         chk($sformatf("v%0d.pc_write_t2", k), 32'(pc_write), 32'd0);
         chk($sformatf("v%0d.busy_t2", k), 32'(busy), 32'd0);
      end

      // Overflow exception, cycle-exact with MEM_LAT=2
      @(negedge clk);
      exc_ovf = 1;
      sb.push_back({3'b100, 1'b1});
      @(negedge clk);
      clear_in();
      chk("ovf.t1.epc_write", 32'(epc_write), 32'd1);
      chk("ovf.t1.mem_read", 32'(mem_read), 32'd1);
      chk("ovf.t1.pc_write", 32'(pc_write), 32'd0);
      chk("ovf.t1.vec_addr", vec_addr, 32'd254);
      chk("ovf.t1.exc_cause", 32'(exc_cause), 32'd2);
      chk("ovf.t1.busy", 32'(busy), 32'd1);
      for (int c = 2; c <= 3; c++) begin
         @(negedge clk);
         chk($sformatf("ovf.t%0d.vec_addr", c), vec_addr, 32'd254);
         chk($sformatf("ovf.t%0d.mem_read", c), 32'(mem_read), 32'd0);
         chk($sformatf("ovf.t%0d.epc_write", c), 32'(epc_write), 32'd0);
         chk($sformatf("ovf.t%0d.done", c), 32'(done), 32'd0);
         chk($sformatf("ovf.t%0d.busy", c), 32'(busy), 32'd1);
      end
      @(negedge clk);
      chk("ovf.t4.busy", 32'(busy), 32'd1);
      chk("ovf.t4.epc_write", 32'(epc_write), 32'd0);
      wait_done("ovf.t4", 0);
      @(negedge clk);
      chk("ovf.t5.busy", 32'(busy), 32'd0);
      chk("ovf.t5.pc_write", 32'(pc_write), 32'd0);
      chk("ovf.t5.vec_addr", vec_addr, 32'd0);
      chk("ovf.t5.exc_cause", 32'(exc_cause), 32'd2);

      // Priority: opcode beats div0 and jump
      @(negedge clk);
      exc_opcode = 1; exc_div0 = 1; req_jump = 1;
      sb.push_back({3'b100, 1'b1});
      @(negedge clk);
      clear_in();
      chk("prio.vec_addr", vec_addr, 32'd255);
      chk("prio.exc_cause", 32'(exc_cause), 32'd1);
      chk("prio.pc_write", 32'(pc_write), 32'd0);
      wait_done("prio", 6);
      @(negedge clk);
      chk("prio.idle", 32'(busy), 32'd0);

      // Requests during the exception sequence are dropped
      @(negedge clk);
      exc_div0 = 1;
      sb.push_back({3'b100, 1'b1});
      @(negedge clk);
      clear_in();
      chk("drop.vec_addr", vec_addr, 32'd253);
      chk("drop.exc_cause", 32'(exc_cause), 32'd3);
      @(negedge clk);
      req_seq = 1;
      @(negedge clk);
      req_seq = 0;
      chk("drop.t3.pc_write", 32'(pc_write), 32'd0);
      wait_done("drop", 4);
      pw_cnt = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (pc_write === 1'b1) pw_cnt++;
      end
      chk("drop.extra_pc_write", 32'(pw_cnt), 32'd0);
      chk("drop.idle", 32'(busy), 32'd0);

      // Asynchronous reset while waiting on the vector byte
      @(negedge clk);
      exc_ovf = 1;
      @(negedge clk);
      clear_in();
      @(negedge clk);
      chk("rmid.pre_busy", 32'(busy), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("rmid.PC_Src", 32'(PC_Src), 32'd1);
      chk("rmid.busy", 32'(busy), 32'd0);
      chk("rmid.vec_addr", vec_addr, 32'd0);
      chk("rmid.exc_cause", 32'(exc_cause), 32'd0);
      chk("rmid.strobes", {28'd0, pc_write, epc_write, mem_read, done}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      req_seq = 1;
      sb.push_back({3'b001, 1'b1});
      @(negedge clk);
      clear_in();
      wait_done("rmid.seq", 0);
      chk("rmid.sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
